// File: rtl/reg_window_file_if.sv
// rtl/reg_window_file_if.sv - windowed register file port bundle
interface reg_window_file_if #(
    parameter int WORD_WIDTH = 16,
    parameter int NIB_WIDTH  = 4,
    parameter int WIN_WIDTH  = 2
);
    logic [NIB_WIDTH-1:0]  rd_a_num;
    logic [WORD_WIDTH-1:0] rd_a_data;
    logic [NIB_WIDTH-1:0]  rd_b_num;
    logic [WORD_WIDTH-1:0] rd_b_data;
    logic [NIB_WIDTH-1:0]  wr_num;
    logic [WORD_WIDTH-1:0] wr_val;
    logic                  set;
    logic                  push;
    logic                  pop;
    logic [WIN_WIDTH-1:0]  win;
    logic                  busy;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output rd_a_num, rd_b_num, wr_num, wr_val, set, push, pop,
        input  rd_a_data, rd_b_data, win, busy, overflow, underflow
    );

    modport slave (
        input  rd_a_num, rd_b_num, wr_num, wr_val, set, push, pop,
        output rd_a_data, rd_b_data, win, busy, overflow, underflow
    );
endinterface

// File: rtl/reg_window_file.sv
// rtl/reg_window_file.sv - register file with push/pop windows and bypassed reads
module reg_window_file #(
    parameter int WORD_WIDTH = 16,
    parameter int NIB_WIDTH  = 4,
    parameter int WIN_WIDTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    reg_window_file_if.slave  bus
);
    localparam int AW    = WIN_WIDTH + NIB_WIDTH;
    localparam int DEPTH = 1 << AW;

    localparam logic [WIN_WIDTH-1:0] WIN_ONE = 1;
    localparam logic [WIN_WIDTH-1:0] WIN_MAX = '1;
    localparam logic [WIN_WIDTH-1:0] WIN_MIN = '0;
    localparam logic [NIB_WIDTH-1:0] NIB_ONE = 1;
    localparam logic [NIB_WIDTH-1:0] NIB_MAX = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state;
    logic [NIB_WIDTH-1:0]  cnt;
    logic [WIN_WIDTH-1:0]  win;
    logic                  overflow;
    logic                  underflow;
    logic [WORD_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i[AW-1:0]] <= '0;
            end
            state     <= IDLE;
            cnt       <= '0;
            win       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A write always lands in the window current at this edge,
                    // even when the same edge moves the window pointer.
                    if (bus.set) begin
                        mem[{win, bus.wr_num}] <= bus.wr_val;
                    end
                    if (bus.push && !bus.pop) begin
                        if (win == WIN_MAX) begin
                            overflow <= 1'b1;
                        end else begin
                            win   <= win + WIN_ONE;
                            cnt   <= '0;
                            state <= CLEAR;
                        end
                    end else if (bus.pop && !bus.push) begin
                        if (win == WIN_MIN) begin
                            underflow <= 1'b1;
                        end else begin
                            win <= win - WIN_ONE;
                        end
                    end
                end
                CLEAR: begin
                    // Requests arriving here are dropped, not queued.
                    mem[{win, cnt}] <= '0;
                    cnt             <= cnt + NIB_ONE;
                    if (cnt == NIB_MAX) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.rd_a_data = mem[{win, bus.rd_a_num}];
        bus.rd_b_data = mem[{win, bus.rd_b_num}];
        if (state == CLEAR) begin
            bus.rd_a_data = '0;
            bus.rd_b_data = '0;
        end else if (bus.set) begin
            if (bus.wr_num == bus.rd_a_num) bus.rd_a_data = bus.wr_val;
            if (bus.wr_num == bus.rd_b_num) bus.rd_b_data = bus.wr_val;
        end
    end

    assign bus.win       = win;
    assign bus.busy      = (state == CLEAR);
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
endmodule

// File: tb/tb_reg_window_file.sv
// tb/tb_reg_window_file.sv - directed self-checking bench for reg_window_file
module tb_reg_window_file;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n;

    always #5 clk = ~clk;

    reg_window_file_if #(.WORD_WIDTH(16), .NIB_WIDTH(4), .WIN_WIDTH(2)) bus ();

    reg_window_file #(.WORD_WIDTH(16), .NIB_WIDTH(4), .WIN_WIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.set  = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] r, input logic [15:0] v);
        bus.set = 1'b1; bus.wr_num = r; bus.wr_val = v;
        step();
        bus.set = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] r, input logic [15:0] v);
        bus.rd_a_num = r; bus.rd_b_num = r;
        #1;
        chk({tag, "_a"}, 32'(bus.rd_a_data), 32'(v));
        chk({tag, "_b"}, 32'(bus.rd_b_data), 32'(v));
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 64) begin
            cycles++;
            step();
        end
    endtask

    task automatic all_zero(input string tag);
        for (int r = 0; r < 16; r++) rd(tag, 4'(r), 16'h0000);
    endtask

    initial begin
        quiet();
        bus.rd_a_num = '0; bus.rd_b_num = '0; bus.wr_num = '0; bus.wr_val = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_win", 32'(bus.win), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_unf", 32'(bus.underflow), 0);
        all_zero("rst_reg");

        wr(4'd3, 16'h1234);
        wr(4'd7, 16'hBEEF);
        bus.rd_a_num = 4'd3; bus.rd_b_num = 4'd7;
        #1;
        chk("rd_a_r3", 32'(bus.rd_a_data), 32'h1234);
        chk("rd_b_r7", 32'(bus.rd_b_data), 32'hBEEF);

        // bypass: checked before the edge that commits the write
        bus.set = 1'b1; bus.wr_num = 4'd5; bus.wr_val = 16'h00AA;
        bus.rd_a_num = 4'd5; bus.rd_b_num = 4'd5;
        #1;
        chk("byp_a", 32'(bus.rd_a_data), 32'h00AA);
        chk("byp_b", 32'(bus.rd_b_data), 32'h00AA);
        step();
        bus.set = 1'b0;
        rd("r5_committed", 4'd5, 16'h00AA);

        wr(4'd2, 16'h5555);
        bus.push = 1'b1;
        step();
        bus.push = 1'b0;
        chk("push_win", 32'(bus.win), 1);
        chk("push_busy", 32'(bus.busy), 1);
        rd("clear_reads0", 4'd3, 16'h0000);
        wait_idle(n);
        chk("busy_len", n, 16);
        chk("win1", 32'(bus.win), 1);
        rd("w1_r2_clear", 4'd2, 16'h0000);
        wr(4'd2, 16'h7777);
        rd("w1_r2", 4'd2, 16'h7777);
        bus.pop = 1'b1;
        step();
        bus.pop = 1'b0;
        chk("pop_win", 32'(bus.win), 0);
        chk("pop_busy", 32'(bus.busy), 0);
        rd("w0_r2", 4'd2, 16'h5555);
        bus.push = 1'b1;
        step();
        bus.push = 1'b0;
        wait_idle(n);
        chk("busy_len2", n, 16);
        rd("w1_r2_recleared", 4'd2, 16'h0000);
        bus.pop = 1'b1;
        step();
        bus.pop = 1'b0;
        chk("back_w0", 32'(bus.win), 0);

        // push+pop together is a window no-op, but the write still commits
        bus.push = 1'b1; bus.pop = 1'b1;
        bus.set = 1'b1; bus.wr_num = 4'd4; bus.wr_val = 16'h4444;
        step();
        quiet();
        chk("pp_win", 32'(bus.win), 0);
        chk("pp_busy", 32'(bus.busy), 0);
        chk("pp_ovf", 32'(bus.overflow), 0);
        chk("pp_unf", 32'(bus.underflow), 0);
        rd("pp_r4", 4'd4, 16'h4444);

        // write with push goes to the old window
        bus.push = 1'b1;
        bus.set = 1'b1; bus.wr_num = 4'd9; bus.wr_val = 16'h0909;
        step();
        quiet();
        wait_idle(n);
        chk("busy_len3", n, 16);
        rd("w1_r9", 4'd9, 16'h0000);
        bus.pop = 1'b1;
        step();
        bus.pop = 1'b0;
        rd("w0_r9", 4'd9, 16'h0909);

        // requests during busy are dropped
        bus.push = 1'b1;
        step();
        bus.push = 1'b0;
        bus.set = 1'b1; bus.wr_num = 4'd1; bus.wr_val = 16'hFFFF; bus.pop = 1'b1;
        step(); step();
        quiet();
        bus.push = 1'b1;
        step();
        bus.push = 1'b0;
        wait_idle(n);
        chk("busy_len4", n, 13);
        chk("busy_drop_win", 32'(bus.win), 1);
        chk("busy_drop_unf", 32'(bus.underflow), 0);
        rd("busy_drop_r1", 4'd1, 16'h0000);

        for (int k = 0; k < 2; k++) begin
            bus.push = 1'b1;
            step();
            bus.push = 1'b0;
            wait_idle(n);
        end
        chk("win3", 32'(bus.win), 3);
        chk("no_ovf_yet", 32'(bus.overflow), 0);
        bus.push = 1'b1;
        step();
        bus.push = 1'b0;
        chk("ovf", 32'(bus.overflow), 1);
        chk("ovf_win", 32'(bus.win), 3);
        chk("ovf_busy", 32'(bus.busy), 0);
        for (int k = 0; k < 3; k++) begin
            bus.pop = 1'b1;
            step();
            bus.pop = 1'b0;
            chk("pop_seq_win", 32'(bus.win), 32'(2 - k));
        end
        chk("no_unf_yet", 32'(bus.underflow), 0);
        bus.pop = 1'b1;
        step();
        bus.pop = 1'b0;
        chk("unf", 32'(bus.underflow), 1);
        chk("unf_win", 32'(bus.win), 0);
        step(); step(); step();
        chk("ovf_sticky", 32'(bus.overflow), 1);
        chk("unf_sticky", 32'(bus.underflow), 1);
        rd("w0_r3_kept", 4'd3, 16'h1234);

        // reset during the 5th busy cycle
        wr(4'd6, 16'h6666);
        bus.push = 1'b1;
        step();
        bus.push = 1'b0;
        step(); step(); step(); step();
        chk("mid_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_win", 32'(bus.win), 0);
        chk("mrst_ovf", 32'(bus.overflow), 0);
        chk("mrst_unf", 32'(bus.underflow), 0);
        all_zero("mrst_reg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
